// File: rtl/adder_eval_pkg.sv
// Shared types and widths for the approximate-adder error sweep controller.
package adder_eval_pkg;

  localparam int unsigned N_IN_W  = 4;
  localparam int unsigned N_OUT_W = 3;
  localparam int unsigned ERR_W   = 3;
  localparam int unsigned CNT_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/exact_ref_adder.sv
// Exact reference: sum of the low and high halves of the input vector.
module exact_ref_adder #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 3
) (
  input  logic [N_IN-1:0]  i_vec,
  output logic [N_OUT-1:0] o_sum
);

  localparam int unsigned HALF = N_IN / 2;

  assign o_sum = N_OUT'(i_vec[HALF-1:0]) + N_OUT'(i_vec[N_IN-1:HALF]);

endmodule

// File: rtl/sop_err_sweep_ctrl.sv
// Sweeps every input vector through an approximate adder and tracks the
// error against the exact sum: threshold-exceed count, max error and worst vector.
module sop_err_sweep_ctrl
  import adder_eval_pkg::*;
#(
  parameter int unsigned N_IN   = N_IN_W,
  parameter int unsigned N_OUT  = N_OUT_W,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ERR_W-1:0] et,
  output logic [N_IN-1:0]  vec_o,
  input  logic [N_OUT-1:0] dut_res_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] max_err,
  output logic [CNT_W-1:0] err_count,
  output logic [N_IN-1:0]  worst_vec
);

  localparam int unsigned SET_W  = 4;
  localparam int unsigned DIFF_W = N_OUT + 1;
  localparam logic [N_IN-1:0]  LAST_VEC = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(16);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [N_IN-1:0]    r_vec;
  logic [SET_W-1:0]   r_settle;
  logic [ERR_W-1:0]   r_et;
  logic [ERR_W-1:0]   r_max;
  logic [CNT_W-1:0]   r_cnt;
  logic [N_IN-1:0]    r_worst;
  logic               r_busy;
  logic               r_done;
  logic               r_pass;

  logic [N_OUT-1:0]         w_exact;
  logic signed [DIFF_W-1:0] w_diff;
  logic signed [DIFF_W-1:0] w_abs;
  logic [ERR_W-1:0]         w_err;
  logic [CNT_W-1:0]         w_cnt_nxt;

  exact_ref_adder #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) u_exact (
    .i_vec (r_vec),
    .o_sum (w_exact)
  );

  // Absolute error, widened by one sign bit then truncated to the error width.
  always_comb begin
    w_diff    = $signed({1'b0, w_exact}) - $signed({1'b0, dut_res_i});
    w_abs     = w_diff[DIFF_W-1] ? -w_diff : w_diff;
    w_err     = ERR_W'(w_abs);
    w_cnt_nxt = r_cnt;
    if ((w_err > r_et) && (r_cnt != CNT_MAX)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_DRIVE;
      ST_DRIVE:  if (r_settle == SET_LAST) w_state_nxt = ST_SAMPLE;
      ST_SAMPLE: w_state_nxt = (r_vec == LAST_VEC) ? ST_DONE : ST_DRIVE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and registered outputs, keyed off the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec    <= '0;
      r_settle <= '0;
      r_et     <= '0;
      r_max    <= '0;
      r_cnt    <= '0;
      r_worst  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_busy   <= 1'b1;
            r_et     <= et;
            r_vec    <= '0;
            r_settle <= '0;
            r_max    <= '0;
            r_cnt    <= '0;
            r_worst  <= '0;
            r_pass   <= 1'b0;
          end
        end
        ST_DRIVE: r_settle <= r_settle + SET_W'(1);
        ST_SAMPLE: begin
          r_cnt <= w_cnt_nxt;
          if (w_err > r_max) begin
            r_max   <= w_err;
            r_worst <= r_vec;
          end
          if (r_vec == LAST_VEC) begin
            r_done <= 1'b1;
            r_pass <= (w_cnt_nxt == '0);
          end else begin
            r_vec    <= r_vec + N_IN'(1);
            r_settle <= '0;
          end
        end
        ST_DONE: begin
          r_busy <= 1'b0;
          r_vec  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign vec_o     = r_vec;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign max_err   = r_max;
  assign err_count = r_cnt;
  assign worst_vec = r_worst;

endmodule

// File: tb/tb_sop_err_sweep_ctrl.sv
// Randomized self-checking bench for sop_err_sweep_ctrl against a sweep-level model.
module tb_sop_err_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] et;
  logic [3:0] vec_o;
  logic [2:0] dut_res;
  logic       busy, done, pass;
  logic [2:0] max_err;
  logic [4:0] err_count;
  logic [3:0] worst_vec;

  logic       start3;
  logic [3:0] vec3;
  logic [2:0] res3;
  logic       busy3, done3, pass3;
  logic [2:0] max3;
  logic [4:0] cnt3;
  logic [3:0] worst3;

  logic [1:0] mode;   // 0 loopback, 1 zero, 2 exact+1, 3 random table
  logic [2:0] lut [16];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sop_err_sweep_ctrl #(.N_IN(4), .N_OUT(3), .SETTLE(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .et(et), .vec_o(vec_o),
    .dut_res_i(dut_res), .busy(busy), .done(done), .pass(pass),
    .max_err(max_err), .err_count(err_count), .worst_vec(worst_vec)
  );

  sop_err_sweep_ctrl #(.N_IN(4), .N_OUT(3), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .et(3'd0), .vec_o(vec3),
    .dut_res_i(res3), .busy(busy3), .done(done3), .pass(pass3),
    .max_err(max3), .err_count(cnt3), .worst_vec(worst3)
  );

  // Stand-in approximate circuit
  always_comb begin
    case (mode)
      2'd0:    dut_res = 3'(vec_o[1:0]) + 3'(vec_o[3:2]);
      2'd1:    dut_res = 3'd0;
      2'd2:    dut_res = 3'(vec_o[1:0]) + 3'(vec_o[3:2]) + 3'd1;
      default: dut_res = lut[vec_o];
    endcase
  end
  assign res3 = 3'(vec3[1:0]) + 3'(vec3[3:2]);

  // Sweep-level model: walk all 16 vectors with integer arithmetic.
  function automatic void ref_sweep(input int m, input int et_v,
                                    output int cnt, output int mx, output int worst);
    int ex, r, e;
    cnt = 0; mx = 0; worst = 0;
    for (int v = 0; v < 16; v++) begin
      ex = (v % 4) + (v / 4);
      case (m)
        0: r = ex;
        1: r = 0;
        2: r = (ex + 1) % 8;
        default: r = int'(lut[v]);
      endcase
      e = ex - r;
      if (e < 0) e = -e;
      e = e % 8;
      if (e > et_v && cnt < 16) cnt++;
      if (e > mx) begin mx = e; worst = v; end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a sweep on u_dut and waits (bounded) for done; reports cycle count and
  // how many in-sweep cycles had an unexpected vec_o or busy.
  task automatic run_sweep(input int et_v, input bit spam,
                           output int cyc, output int seq_bad);
    start = 1'b1;
    et = 3'(et_v);
    tick();
    if (!spam) start = 1'b0;
    et = 3'($urandom_range(0, 7));
    cyc = 1;
    seq_bad = 0;
    while (cyc < 200 && done !== 1'b1) begin
      if (vec_o !== 4'((cyc - 1) / 2) || busy !== 1'b1) seq_bad++;
      tick();
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start3 = 1'b0; et = 3'd0; mode = 2'd0;
    tick(); tick();
    rst = 1'b0;
    n_vec++;
    if ({vec_o, busy, done, pass, max_err, err_count, worst_vec} !== 19'd0) begin
      n_err++;
      $display("FAIL reset outputs got=%h want=0", {vec_o, busy, done, pass, max_err, err_count, worst_vec});
    end
    n_vec++;
    if ({vec3, busy3, done3, pass3, max3, cnt3, worst3} !== 19'd0) begin
      n_err++;
      $display("FAIL reset3 outputs got=%h want=0", {vec3, busy3, done3, pass3, max3, cnt3, worst3});
    end
  endtask

  task automatic test_fixed(input logic [1:0] m, input int et_v);
    int cyc, bad, c, mx, w;
    mode = m;
    ref_sweep(int'(m), et_v, c, mx, w);
    run_sweep(et_v, 1'b0, cyc, bad);
    n_vec++;
    if (cyc != 33) begin n_err++; $display("FAIL latency mode%0d got=%0d want=33", m, cyc); end
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL sequence mode%0d bad_cycles=%0d want=0", m, bad); end
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL busy_in_done got=%b want=1", busy); end
    n_vec++;
    if (pass !== (c == 0)) begin n_err++; $display("FAIL pass mode%0d et%0d got=%b want=%b", m, et_v, pass, c == 0); end
    n_vec++;
    if (err_count !== 5'(c)) begin n_err++; $display("FAIL err_count mode%0d et%0d got=%0d want=%0d", m, et_v, err_count, c); end
    n_vec++;
    if (max_err !== 3'(mx)) begin n_err++; $display("FAIL max_err mode%0d got=%0d want=%0d", m, max_err, mx); end
    n_vec++;
    if (worst_vec !== 4'(w)) begin n_err++; $display("FAIL worst_vec mode%0d got=%0d want=%0d", m, worst_vec, w); end
    tick();
    n_vec++;
    if ({done, busy, vec_o} !== 6'd0) begin n_err++; $display("FAIL after_done done/busy/vec got=%h want=0", {done, busy, vec_o}); end
    n_vec++;
    if ({pass, max_err, err_count, worst_vec} !== {1'(c == 0), 3'(mx), 5'(c), 4'(w)}) begin
      n_err++;
      $display("FAIL hold_idle got=%h want=%h", {pass, max_err, err_count, worst_vec}, {1'(c == 0), 3'(mx), 5'(c), 4'(w)});
    end
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      for (int v = 0; v < 16; v++) lut[v] = 3'($urandom_range(0, 7));
      test_fixed(2'd3, int'($urandom_range(0, 7)));
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bad, c, mx, w, n_done;
    for (int v = 0; v < 16; v++) lut[v] = 3'($urandom_range(0, 7));
    mode = 2'd3;
    ref_sweep(3, 2, c, mx, w);
    run_sweep(2, 1'b1, cyc, bad);
    n_done = (done === 1'b1) ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done === 1'b1) n_done++;
    end
    n_vec++;
    if (n_done != 1 || cyc != 33) begin n_err++; $display("FAIL b2b done_pulses got=%0d cyc=%0d want=1/33", n_done, cyc); end
    n_vec++;
    if ({pass, max_err, err_count, worst_vec} !== {1'(c == 0), 3'(mx), 5'(c), 4'(w)}) begin
      n_err++;
      $display("FAIL b2b results got=%h want=%h", {pass, max_err, err_count, worst_vec}, {1'(c == 0), 3'(mx), 5'(c), 4'(w)});
    end
  endtask

  task automatic test_midsweep_reset();
    int n, cyc, bad, c, mx, w, etv;
    mode = 2'd1;
    start = 1'b1; et = 3'd0;
    tick();
    start = 1'b0;
    n = 0;
    while (vec_o !== 4'd7 && n < 100) begin tick(); n++; end
    n_vec++;
    if (vec_o !== 4'd7) begin n_err++; $display("FAIL midsweep reach7 got=%0d want=7", vec_o); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if ({vec_o, busy, done, pass, max_err, err_count, worst_vec} !== 19'd0) begin
      n_err++;
      $display("FAIL midsweep_rst outputs got=%h want=0", {vec_o, busy, done, pass, max_err, err_count, worst_vec});
    end
    tick();
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL midsweep_idle busy got=%b want=0", busy); end
    etv = int'($urandom_range(0, 7));
    ref_sweep(1, etv, c, mx, w);
    run_sweep(etv, 1'b0, cyc, bad);
    n_vec++;
    if (cyc != 33 || {err_count, max_err, worst_vec} !== {5'(c), 3'(mx), 4'(w)}) begin
      n_err++;
      $display("FAIL rerun cyc=%0d got=%h want=%h", cyc, {err_count, max_err, worst_vec}, {5'(c), 3'(mx), 4'(w)});
    end
    tick(); tick();
  endtask

  task automatic test_rst_priority();
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    tick();
    n_vec++;
    if (busy !== 1'b0 || vec_o !== 4'd0) begin n_err++; $display("FAIL rst_priority busy=%b vec=%0d want=0/0", busy, vec_o); end
  endtask

  task automatic test_settle3();
    int cyc, bad;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    cyc = 1; bad = 0;
    while (cyc < 300 && done3 !== 1'b1) begin
      if (vec3 !== 4'((cyc - 1) / 4)) bad++;
      tick();
      cyc++;
    end
    n_vec++;
    if (cyc != 65) begin n_err++; $display("FAIL settle3 latency got=%0d want=65", cyc); end
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL settle3 vec_hold bad_cycles=%0d want=0", bad); end
    n_vec++;
    if ({pass3, max3, cnt3, worst3} !== {1'b1, 12'd0}) begin
      n_err++;
      $display("FAIL settle3 results got=%h want=%h", {pass3, max3, cnt3, worst3}, {1'b1, 12'd0});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_fixed(2'd0, 0);
    test_fixed(2'd1, 1);
    test_fixed(2'd2, 1);
    test_fixed(2'd2, 0);
    test_random();
    test_back_to_back();
    test_midsweep_reset();
    test_rst_priority();
    test_settle3();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
